// File: rtl/vector_rf_sb.sv
// Vector register file: NREGS x (LANES x EW), 3 combinational read ports, one lane-masked
// write port, per-register pending-write scoreboard, and a sequential bulk-clear engine.
// Optional feature macro: VRF_WRITE_BYPASS_EN (forward the in-flight write to the read ports).
module vector_rf_sb #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned LANES = 16,
    parameter int unsigned EW    = 16,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              rs1,
    input  logic [AW-1:0]              rs2,
    input  logic [AW-1:0]              rs3,
    output logic [LANES-1:0][EW-1:0]   rd1,
    output logic [LANES-1:0][EW-1:0]   rd2,
    output logic [LANES-1:0][EW-1:0]   rd3,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic                       rs3_busy,
    input  logic                       we,
    input  logic [AW-1:0]              wa,
    input  logic [LANES-1:0][EW-1:0]   wd,
    input  logic [LANES-1:0]           wmask,
    input  logic                       rsv_valid,
    input  logic [AW-1:0]              rsv_addr,
    input  logic                       clr_start,
    output logic                       clr_busy,
    output logic                       clr_done
);

    typedef logic [LANES-1:0][EW-1:0] vec_t;
    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q;
    logic [AW-1:0]     cnt_q;
    logic              clr_busy_q;
    logic              clr_done_q;
    vec_t              regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic              idle;

    logic [AW-1:0]     raddr [3];
    vec_t              rdata [3];
    logic              rbusy [3];

    assign idle     = (state_q == StIdle);
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // Clear-engine FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_start) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q    <= StDone;
                        clr_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Register contents and scoreboard: writes/reservations in IDLE, one-per-cycle wipe in CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else if (idle) begin
            if (we) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        regs_q[wa][l] <= wd[l];
                    end
                end
                busy_q[wa] <= 1'b0;
            end
            // Later assignment wins: a fresh reservation overrides the retiring write.
            if (rsv_valid) begin
                busy_q[rsv_addr] <= 1'b1;
            end
        end else if (state_q == StClear) begin
            regs_q[cnt_q] <= '0;
            busy_q[cnt_q] <= 1'b0;
        end
    end

    assign raddr[0] = rs1;
    assign raddr[1] = rs2;
    assign raddr[2] = rs3;

    // Combinational read ports, optionally forwarding the write accepted this cycle.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata[p] = regs_q[raddr[p]];
            rbusy[p] = busy_q[raddr[p]];
`ifdef VRF_WRITE_BYPASS_EN
            if (we && idle && (raddr[p] == wa)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        rdata[p][l] = wd[l];
                    end
                end
                rbusy[p] = 1'b0;
            end
`endif
        end
    end

    assign rd1      = rdata[0];
    assign rd2      = rdata[1];
    assign rd3      = rdata[2];
    assign rs1_busy = rbusy[0];
    assign rs2_busy = rbusy[1];
    assign rs3_busy = rbusy[2];

endmodule

// File: tb/tb_vector_rf_sb.sv
// Scoreboard bench for vector_rf_sb: a driver pushes the expected read/status view of each cycle,
// a negedge monitor pops and compares. Reference model uses plain arrays and an integer clear index.
module tb_vector_rf_sb;

    localparam int NREGS = 32;
    localparam int LANES = 16;
    localparam int EW    = 16;
    localparam int AW    = 5;

    typedef logic [LANES-1:0][EW-1:0] vec_t;
    typedef struct packed {
        vec_t rd1;
        vec_t rd2;
        vec_t rd3;
        logic b1;
        logic b2;
        logic b3;
        logic cb;
        logic cd;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [AW-1:0]    rs1 = '0, rs2 = '0, rs3 = '0;
    vec_t             rd1, rd2, rd3;
    logic             rs1_busy, rs2_busy, rs3_busy;
    logic             we = 1'b0;
    logic [AW-1:0]    wa = '0;
    vec_t             wd = '0;
    logic [LANES-1:0] wmask = '0;
    logic             rsv_valid = 1'b0;
    logic [AW-1:0]    rsv_addr = '0;
    logic             clr_start = 1'b0;
    logic             clr_busy, clr_done;

    vector_rf_sb #(.NREGS(NREGS), .LANES(LANES), .EW(EW)) dut (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy),
        .we(we), .wa(wa), .wd(wd), .wmask(wmask),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Reference model: contents, pending bits, clear position (-1 idle, 0..NREGS-1 wiping, NREGS done)
    logic [EW-1:0] mem [NREGS][LANES];
    bit            pend [NREGS];
    int            cpos;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            pend[r] = 0;
            for (int l = 0; l < LANES; l++) mem[r][l] = '0;
        end
        cpos = -1;
    endtask

    // Expected read view of one port given the currently driven inputs.
    task automatic exp_port(input logic [AW-1:0] a, output vec_t d, output logic b);
        for (int l = 0; l < LANES; l++) d[l] = mem[a][l];
        b = pend[a];
`ifdef VRF_WRITE_BYPASS_EN
        if (!rst && we && cpos < 0 && a == wa) begin
            for (int l = 0; l < LANES; l++) if (wmask[l]) d[l] = wd[l];
            b = 1'b0;
        end
`endif
    endtask

    task automatic push_exp();
        exp_t e;
        exp_port(rs1, e.rd1, e.b1);
        exp_port(rs2, e.rd2, e.b2);
        exp_port(rs3, e.rd3, e.b3);
        e.cb = (cpos >= 0);
        e.cd = (cpos == NREGS);
        q.push_back(e);
    endtask

    // Apply the effect of one clock edge to the model.
    task automatic model_edge();
        if (cpos < 0) begin
            if (we) begin
                for (int l = 0; l < LANES; l++) if (wmask[l]) mem[wa][l] = wd[l];
                pend[wa] = 0;
            end
            if (rsv_valid) pend[rsv_addr] = 1;
            if (clr_start) cpos = 0;
        end else if (cpos < NREGS) begin
            for (int l = 0; l < LANES; l++) mem[cpos][l] = '0;
            pend[cpos] = 0;
            cpos++;
        end else begin
            cpos = -1;
        end
    endtask

    task automatic step(input logic i_we, input logic [AW-1:0] i_wa, input vec_t i_wd,
                        input logic [LANES-1:0] i_wm, input logic i_rsv,
                        input logic [AW-1:0] i_ra, input logic i_clr,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3);
        we = i_we; wa = i_wa; wd = i_wd; wmask = i_wm;
        rsv_valid = i_rsv; rsv_addr = i_ra; clr_start = i_clr;
        rs1 = a1; rs2 = a2; rs3 = a3;
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [AW-1:0] a3);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, a1, a2, a3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        we = 1'b0; rsv_valid = 1'b0; clr_start = 1'b0;
        model_reset();
        push_exp();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = EW'($urandom);
        return v;
    endfunction

    function automatic vec_t fill_vec(input logic [EW-1:0] x);
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = x;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [LANES*EW-1:0] got,
                       input logic [LANES*EW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: outputs are always presented, so compare one expectation per cycle.
    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd1", rd1, e.rd1);
            chk("rd2", rd2, e.rd2);
            chk("rd3", rd3, e.rd3);
            chk("rs1_busy", {255'b0, rs1_busy}, {255'b0, e.b1});
            chk("rs2_busy", {255'b0, rs2_busy}, {255'b0, e.b2});
            chk("rs3_busy", {255'b0, rs3_busy}, {255'b0, e.b3});
            chk("clr_busy", {255'b0, clr_busy}, {255'b0, e.cb});
            chk("clr_done", {255'b0, clr_done}, {255'b0, e.cd});
        end
    end

    initial begin
        int wait_cyc;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state visible on every address
        for (int r = 0; r < NREGS; r++)
            idle_read(AW'(r), AW'((r + 1) % NREGS), AW'((r + 2) % NREGS));

        // Masked writes to reg 5, read in write cycle and after
        step(1'b1, 5'd5, fill_vec(16'hA5A5), 16'h00FF, 1'b0, '0, 1'b0, 5'd5, 5'd5, 5'd0);
        step(1'b1, 5'd5, fill_vec(16'h1234), 16'hFF00, 1'b0, '0, 1'b0, 5'd5, 5'd4, 5'd5);
        idle_read(5'd5, 5'd5, 5'd5);

        // Scoreboard: reserve, set-wins collision, retire
        step(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 5'd6);
        idle_read(5'd0, 5'd7, 5'd7);
        step(1'b1, 5'd7, rand_vec(), 16'hFFFF, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7, 5'd7);
        step(1'b1, 5'd7, rand_vec(), 16'h0000, 1'b0, '0, 1'b0, 5'd7, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7, 5'd7);

        // Bulk clear over a fully populated file, with dropped write/reserve mid-clear
        for (int r = 0; r < NREGS; r++) begin
            vec_t v;
            v = rand_vec();
            v[0] = v[0] | 16'h1;
            step(1'b1, AW'(r), v, 16'hFFFF, 1'b0, '0, 1'b0, AW'(r), 5'd3, 5'd9);
        end
        step(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 5'd3);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 5'd3, 5'd9, 5'd31);
        for (int c = 0; c < NREGS + 2; c++) begin
            if (c == 5) step(1'b1, 5'd9, fill_vec(16'hDEAD), 16'hFFFF, 1'b1, 5'd9, 1'b1,
                             5'd9, 5'd3, 5'd4);
            else idle_read(AW'(c % NREGS), 5'd9, 5'd3);
        end
        for (int r = 0; r < NREGS; r++) idle_read(AW'(r), 5'd9, 5'd3);

        // Reset in the middle of a clear
        for (int r = 20; r < 24; r++)
            step(1'b1, AW'(r), rand_vec(), 16'hFFFF, 1'b1, AW'(r), 1'b0, AW'(r), 5'd20, 5'd2);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 5'd20, 5'd21, 5'd22);
        for (int c = 0; c < 10; c++) idle_read(5'd20, 5'd21, 5'd23);
        do_reset();
        for (int r = 0; r < NREGS; r++) idle_read(AW'(r), AW'((r + 7) % NREGS), 5'd21);

        // Same-cycle read of an in-flight single-lane write
        step(1'b1, 5'd2, rand_vec(), 16'hFFFF, 1'b0, '0, 1'b0, 5'd2, 5'd2, 5'd2);
        step(1'b1, 5'd2, fill_vec(16'hBEEF), 16'h0001, 1'b0, '0, 1'b0, 5'd1, 5'd0, 5'd2);
        idle_read(5'd2, 5'd2, 5'd2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] a, b1, b2, b3;
            a  = AW'($urandom);
            b1 = ($urandom_range(0, 2) == 0) ? a : AW'($urandom);
            b2 = ($urandom_range(0, 2) == 0) ? a : AW'($urandom);
            b3 = AW'($urandom);
            step(1'($urandom), a, rand_vec(), LANES'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? a : AW'($urandom),
                 ($urandom_range(0, 59) == 0), b1, b2, b3);
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
